// File: rtl/fifo4x32_mux_feed_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo4x32_mux_feed_if
// Description : Handshake and storage-view bundle for fifo4x32_mux_feed.
//               The write side is wr_valid/wr_ready/wr_data. The read side is
//               rd_valid/rd_ready. The FIFO also exposes its four storage
//               entries as D0..D3, its head index as S, and its occupancy as
//               count, so a downstream fourmux32 can select the head directly.
//               Modports:
//                 master - writer/reader side (drives wr_valid, wr_data,
//                          rd_ready)
//                 slave  - the FIFO (drives wr_ready, rd_valid, D0..D3, S,
//                          count)
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo4x32_mux_feed_if #(
    parameter int WIDTH = 32
);
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] D0;
    logic [WIDTH-1:0] D1;
    logic [WIDTH-1:0] D2;
    logic [WIDTH-1:0] D3;
    logic [1:0]       S;
    logic [2:0]       count;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, D0, D1, D2, D3, S, count
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, D0, D1, D2, D3, S, count
    );
endinterface
`default_nettype wire

// File: rtl/fifo4x32_mux_feed.sv
`default_nettype none
// ============================================================================
// Module      : fifo4x32_mux_feed
// Description : 4-entry FIFO that feeds a four-way mux. All entries appear in
//               parallel on D0..D3, and the read pointer appears on S, so
//               fourmux32(Y, D0..D3, S) gives the head entry combinationally.
//               wr_ready and rd_valid decode only the registered count. There
//               is no combinational path from wr_valid or rd_ready to them.
//               Ports:
//                 clk   - rising-edge clock
//                 rst_n - asynchronous active-low reset
//                 bus   - fifo4x32_mux_feed_if.slave (handshakes, D0..D3, S,
//                         count)
//               Build option:
//                 FIFO_SCRUB_EN - when defined, a popped entry is cleared to
//                                 zero on the same edge that S advances.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo4x32_mux_feed #(
    parameter int WIDTH = 32
) (
    input  wire                        clk,
    input  wire                        rst_n,
    fifo4x32_mux_feed_if.slave         bus
);
    localparam logic [2:0] c_depth = 3'd4;

    logic [WIDTH-1:0] r_mem [4];
    logic [1:0]       r_wr_ptr;
    logic [1:0]       r_rd_ptr;
    logic [2:0]       r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == 3'd0);
    // Each qualifier contains a known-zero term whenever the corresponding
    // side is blocked. An X on an unqualified input therefore cannot reach
    // the state.
    assign w_push  = bus.wr_valid & ~w_full;
    assign w_pop   = bus.rd_ready & ~w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.wr_data;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
`ifdef FIFO_SCRUB_EN
                // A push to the head slot can only happen when the FIFO is
                // full, and a full FIFO refuses pushes. Placing the clear
                // after the write still makes it win if that case ever arises.
                r_mem[r_rd_ptr] <= '0;
`endif
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.wr_ready = ~w_full;
    assign bus.rd_valid = ~w_empty;
    assign bus.D0       = r_mem[0];
    assign bus.D1       = r_mem[1];
    assign bus.D2       = r_mem[2];
    assign bus.D3       = r_mem[3];
    assign bus.S        = r_rd_ptr;
    assign bus.count    = r_count;
endmodule
`default_nettype wire

// File: tb/tb_fifo4x32_mux_feed.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo4x32_mux_feed
// Description : Self-checking bench for fifo4x32_mux_feed. The reference
//               model has two parts. A queue holds the logical FIFO contents.
//               A slot array, indexed by running push/pop totals modulo 4,
//               holds what D0..D3 should show.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo4x32_mux_feed;
    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    fifo4x32_mux_feed_if #(.WIDTH(WIDTH)) bus ();

    fifo4x32_mux_feed #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_slot [4];
    int               m_wr_total;
    int               m_rd_total;

    function automatic logic [WIDTH-1:0] get_d(input int idx);
        case (idx)
            0:       return bus.D0;
            1:       return bus.D1;
            2:       return bus.D2;
            default: return bus.D3;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] get_y();
        return get_d(int'(bus.S));
    endfunction

    task automatic model_clear();
        m_q.delete();
        for (int i = 0; i < 4; i++) m_slot[i] = '0;
        m_wr_total = 0;
        m_rd_total = 0;
    endtask

    task automatic apply_reset();
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        model_clear();
    endtask

    // Drive one cycle of stimulus, wait for the edge, then update the model.
    task automatic do_cycle(input logic wv, input logic [WIDTH-1:0] wd, input logic rr);
        bit acc_push;
        bit acc_pop;
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        acc_push = wv && (m_q.size() < 4);
        acc_pop  = rr && (m_q.size() > 0);
        @(posedge clk);
        #1;
        if (acc_push) begin
            m_slot[m_wr_total % 4] = wd;
            m_q.push_back(wd);
            m_wr_total++;
        end
        if (acc_pop) begin
`ifdef FIFO_SCRUB_EN
            m_slot[m_rd_total % 4] = '0;
`endif
            void'(m_q.pop_front());
            m_rd_total++;
        end
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        do_cycle(1'b1, 32'hA5A5A5A5, 1'b0);
        do_cycle(1'b1, 32'h5A5A5A5A, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        total++;
        if ({bus.D0, bus.D1, bus.D2, bus.D3} !== '0) begin
            bad++; $display("FAIL reset_data got=%h %h %h %h exp=0", bus.D0, bus.D1, bus.D2, bus.D3);
        end
        total++;
        if (bus.S !== 2'd0 || bus.count !== 3'd0) begin
            bad++; $display("FAIL reset_ptr got S=%0d count=%0d exp S=0 count=0", bus.S, bus.count);
        end
        total++;
        if (bus.rd_valid !== 1'b0 || bus.wr_ready !== 1'b1) begin
            bad++; $display("FAIL reset_hs got rd_valid=%b wr_ready=%b exp 0 1", bus.rd_valid, bus.wr_ready);
        end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) do_cycle(1'b1, 32'h11111111 * i, 1'b0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (get_d(i) !== 32'h11111111 * (i + 1)) begin
                bad++; $display("FAIL fill_d%0d got=%h exp=%h", i, get_d(i), 32'h11111111 * (i + 1));
            end
        end
        total++;
        if (bus.count !== 3'd4 || bus.wr_ready !== 1'b0) begin
            bad++; $display("FAIL fill_full got count=%0d wr_ready=%b exp 4 0", bus.count, bus.wr_ready);
        end
        do_cycle(1'b1, 32'h55555555, 1'b0);
        total++;
        if (bus.D0 !== 32'h11111111 || bus.count !== 3'd4) begin
            bad++; $display("FAIL fill_overflow got D0=%h count=%0d exp 11111111 4", bus.D0, bus.count);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (get_y() !== 32'h11111111 * (i + 1) || bus.S !== 2'(i)) begin
                bad++; $display("FAIL drain_y%0d got Y=%h S=%0d exp Y=%h S=%0d", i, get_y(), bus.S, 32'h11111111 * (i + 1), i);
            end
            do_cycle(1'b0, '0, 1'b1);
        end
        total++;
        if (bus.S !== 2'd0 || bus.rd_valid !== 1'b0 || bus.count !== 3'd0) begin
            bad++; $display("FAIL drain_end got S=%0d rd_valid=%b count=%0d exp 0 0 0", bus.S, bus.rd_valid, bus.count);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
`ifdef FIFO_SCRUB_EN
            if (get_d(i) !== '0) begin
                bad++; $display("FAIL drain_scrub%0d got=%h exp=0", i, get_d(i));
            end
`else
            if (get_d(i) !== 32'h11111111 * (i + 1)) begin
                bad++; $display("FAIL drain_retain%0d got=%h exp=%h", i, get_d(i), 32'h11111111 * (i + 1));
            end
`endif
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        do_cycle(1'b1, 32'h0000000A, 1'b0);
        do_cycle(1'b1, 32'h0000000B, 1'b0);
        do_cycle(1'b1, 32'h0000000C, 1'b0);
        do_cycle(1'b0, '0, 1'b1);
        do_cycle(1'b0, '0, 1'b1);
        do_cycle(1'b1, 32'h0000000D, 1'b0);
        do_cycle(1'b1, 32'h0000000E, 1'b0);
        do_cycle(1'b1, 32'h0000000F, 1'b0);
        total++;
        if (bus.D3 !== 32'hD || bus.D0 !== 32'hE || bus.D1 !== 32'hF) begin
            bad++; $display("FAIL wrap_data got D3=%h D0=%h D1=%h exp D E F", bus.D3, bus.D0, bus.D1);
        end
        total++;
        if (bus.S !== 2'd2 || get_y() !== 32'hC || bus.count !== 3'd4) begin
            bad++; $display("FAIL wrap_head got S=%0d Y=%h count=%0d exp 2 C 4", bus.S, get_y(), bus.count);
        end
    endtask

    task automatic test_simultaneous();
        int old_wr;
        logic [1:0] old_s;
        do_cycle(1'b0, '0, 1'b1);
        do_cycle(1'b0, '0, 1'b1);
        old_wr = m_wr_total % 4;
        old_s  = bus.S;
        do_cycle(1'b1, 32'hDEADBEEF, 1'b1);
        total++;
        if (bus.count !== 3'd2 || bus.S !== old_s + 2'd1 || get_d(old_wr) !== 32'hDEADBEEF) begin
            bad++; $display("FAIL simul_mid got count=%0d S=%0d D[%0d]=%h exp 2 %0d DEADBEEF", bus.count, bus.S, old_wr, get_d(old_wr), old_s + 2'd1);
        end
        do_cycle(1'b0, '0, 1'b1);
        do_cycle(1'b0, '0, 1'b1);
        old_s = bus.S;
        do_cycle(1'b1, 32'hCAFEF00D, 1'b1);
        total++;
        if (bus.count !== 3'd1 || bus.S !== old_s || get_y() !== 32'hCAFEF00D || bus.rd_valid !== 1'b1) begin
            bad++; $display("FAIL simul_empty got count=%0d S=%0d Y=%h rd_valid=%b exp 1 %0d CAFEF00D 1", bus.count, bus.S, get_y(), bus.rd_valid, old_s);
        end
    endtask

    // X on inputs that the handshake does not qualify must leave the state unchanged.
    task automatic test_x_inputs();
        apply_reset();
        bus.wr_valid = 1'b0;
        bus.wr_data  = 'x;
        bus.rd_ready = 1'bx;
        @(posedge clk);
        #1;
        total++;
        if (bus.count !== 3'd0 || bus.S !== 2'd0 || bus.D0 !== '0) begin
            bad++; $display("FAIL x_empty got count=%0d S=%0d D0=%h exp 0 0 0", bus.count, bus.S, bus.D0);
        end
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 32'h100 + i, 1'b0);
        bus.wr_valid = 1'bx;
        bus.wr_data  = 'x;
        bus.rd_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
        total++;
        if (bus.count !== 3'd4 || bus.D0 !== 32'h100 || bus.D3 !== 32'h103) begin
            bad++; $display("FAIL x_full got count=%0d D0=%h D3=%h exp 4 100 103", bus.count, bus.D0, bus.D3);
        end
    endtask

    task automatic test_midop_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 32'h700 + i, 1'b0);
        #3 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        model_clear();
        total++;
        if (bus.count !== 3'd0 || bus.S !== 2'd0 || bus.rd_valid !== 1'b0 || bus.wr_ready !== 1'b1 ||
            {bus.D0, bus.D1, bus.D2, bus.D3} !== '0) begin
            bad++; $display("FAIL midop_reset got count=%0d S=%0d rd_valid=%b wr_ready=%b D0=%h exp reset values", bus.count, bus.S, bus.rd_valid, bus.wr_ready, bus.D0);
        end
        do_cycle(1'b1, 32'h12345678, 1'b0);
        total++;
        if (bus.D0 !== 32'h12345678 || bus.count !== 3'd1) begin
            bad++; $display("FAIL midop_next got D0=%h count=%0d exp 12345678 1", bus.D0, bus.count);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int n = 0; n < 400; n++) begin
            do_cycle(1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 1)));
            total++;
            if (bus.count !== 3'(m_q.size()) || bus.S !== 2'(m_rd_total % 4) ||
                bus.wr_ready !== (m_q.size() < 4) || bus.rd_valid !== (m_q.size() > 0)) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_ctrl cycle=%0d got count=%0d S=%0d exp count=%0d S=%0d", n, bus.count, bus.S, m_q.size(), m_rd_total % 4);
            end
            if (m_q.size() > 0) begin
                total++;
                if (get_y() !== m_q[0]) begin
                    bad++; errs++;
                    if (errs < 10) $display("FAIL rand_head cycle=%0d got=%h exp=%h", n, get_y(), m_q[0]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                total++;
                if (get_d(i) !== m_slot[i]) begin
                    bad++; errs++;
                    if (errs < 10) $display("FAIL rand_slot%0d cycle=%0d got=%h exp=%h", i, n, get_d(i), m_slot[i]);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_x_inputs();
        test_midop_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
